// File: rtl/fft_tw_pkg.sv
// Shared constants and elaboration-time helpers for the twiddle-factor sequencer:
// quadrant boundaries and the quarter-wave cosine table entries.
package fft_tw_pkg;

   localparam int TW_W_DEF = 18;
   localparam int FRAC_DEF = 10;

   function automatic int quarter(input int max_n);
      return max_n / 4;
   endfunction

   function automatic int half(input int max_n);
      return 2 * (max_n / 4);
   endfunction

   function automatic int three_q(input int max_n);
      return 3 * (max_n / 4);
   endfunction

   // round-half-away(2^frac * cos(2*pi*i/max_n)) for i in [0, max_n/4], evaluated with a
   // Q30 Taylor series; cosine is non-negative here, so the rounding is a plain +0.5 floor.
   function automatic int cos_entry(input int i, input int max_n, input int frac);
      longint x;
      longint x2;
      longint term;
      longint sum;
      x    = (64'sd6746518852 * longint'(i)) / longint'(max_n);
      x2   = (x * x) >>> 30;
      term = 64'sd1 <<< 30;
      sum  = term;
      for (int k = 1; k <= 10; k++) begin
         term = -(((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k)));
         sum  = sum + term;
      end
      return int'((sum * (64'sd1 <<< frac) + (64'sd1 <<< 29)) >>> 30);
   endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Configuration request plus valid/ready twiddle stream between a stage controller
// (master) and the twiddle sequencer (slave).
interface twiddle_gen_if #(
   parameter int CNT_W = 11,
   parameter int PH_W  = 11,
   parameter int TW_W  = 18
);
   logic                    start;
   logic [CNT_W-1:0]        cfg_r;
   logic [CNT_W-1:0]        cfg_m;
   logic [PH_W-1:0]         cfg_step;
   logic                    busy;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [TW_W-1:0]  tw_re;
   logic signed [TW_W-1:0]  tw_im;
   logic                    tw_last;

   modport master (
      output start, cfg_r, cfg_m, cfg_step, out_ready,
      input  busy, out_valid, tw_re, tw_im, tw_last
   );

   modport slave (
      input  start, cfg_r, cfg_m, cfg_step, out_ready,
      output busy, out_valid, tw_re, tw_im, tw_last
   );
endinterface

// File: rtl/twiddle_rom_q.sv
// Dual-read quarter-wave cosine ROM, Q+1 entries, with registered outputs that hold
// while the pipeline is stalled.
module twiddle_rom_q
   import fft_tw_pkg::*;
#(
   parameter int MAX_N = 1200,
   parameter int TW_W  = TW_W_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int AW    = $clog2(MAX_N / 4 + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [AW-1:0]          addr_a,
   input  logic [AW-1:0]          addr_b,
   output logic signed [TW_W-1:0] data_a,
   output logic signed [TW_W-1:0] data_b
);

   localparam int Q = quarter(MAX_N);

   logic signed [TW_W-1:0] table_c [0:Q];

   for (genvar i = 0; i <= Q; i++) begin : g_entry
      localparam int VAL = cos_entry(i, MAX_N, FRAC);
      assign table_c[i] = TW_W'(VAL);
   end

   // NOTE: only the read registers are reset; the table is constant logic, not storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_a <= '0;
         data_b <= '0;
      end else if (en) begin
         data_a <= table_c[addr_a];
         data_b <= table_c[addr_b];
      end
   end

endmodule

// File: rtl/twiddle_gen.sv
// Run-time configurable twiddle sequencer: emits W_MAX^(r*m*step) for r<R, m<M through a
// three-stage stallable pipeline (sequencer, quadrant fold, ROM read with sign/swap).
module twiddle_gen
   import fft_tw_pkg::*;
#(
   parameter int MAX_N = 1200,
   parameter int TW_W  = TW_W_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int CNT_W = $clog2(MAX_N + 1),
   parameter int PH_W  = $clog2(MAX_N)
) (
   input  logic         clk,
   input  logic         rst_n,
   twiddle_gen_if.slave bus
);

   localparam int Q  = quarter(MAX_N);
   localparam int AW = $clog2(Q + 1);

   localparam logic [PH_W-1:0] P_Q1  = PH_W'(Q);
   localparam logic [PH_W-1:0] P_Q2  = PH_W'(half(MAX_N));
   localparam logic [PH_W-1:0] P_Q3  = PH_W'(three_q(MAX_N));
   localparam logic [PH_W:0]   P_MAX = (PH_W + 1)'(MAX_N);
   localparam logic [AW-1:0]   A_Q   = AW'(Q);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   // Modular add of two phases already in [0, MAX_N): one conditional subtract suffices.
   function automatic logic [PH_W-1:0] wrap_add(input logic [PH_W-1:0] a,
                                                input logic [PH_W-1:0] b);
      logic [PH_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= P_MAX) s = s - P_MAX;
      return s[PH_W-1:0];
   endfunction

   logic                    en;
   logic                    start_ok;
   logic                    busy_r;

   logic [CNT_W-1:0]        cfg_r_q;
   logic [CNT_W-1:0]        cfg_m_q;
   logic [PH_W-1:0]         step_q;
   logic [CNT_W-1:0]        r_idx;
   logic [CNT_W-1:0]        m_idx;
   logic [PH_W-1:0]         inc;

   logic [PH_W-1:0]         s0_p;
   logic                    s0_valid;
   logic                    s0_last;

   logic [1:0]              s1_q;
   logic [AW-1:0]           s1_o;
   logic                    s1_valid;
   logic                    s1_last;

   logic [1:0]              s2_q;
   logic                    s2_valid;
   logic                    s2_last;
   logic signed [TW_W-1:0]  rd_a;
   logic signed [TW_W-1:0]  rd_b;

   logic                    m_end;
   logic [CNT_W-1:0]        m_nxt;
   logic [CNT_W-1:0]        r_nxt;
   logic                    last_nxt;
   logic [1:0]              q_c;
   logic [AW-1:0]           o_c;
   logic signed [TW_W-1:0]  re_c;
   logic signed [TW_W-1:0]  im_c;

   assign en       = !s2_valid || bus.out_ready;
   assign start_ok = bus.start && !busy_r && (bus.cfg_r != '0) && (bus.cfg_m != '0);

   assign m_end    = (m_idx == cfg_m_q - ONE);
   assign m_nxt    = m_end ? '0 : m_idx + ONE;
   assign r_nxt    = m_end ? r_idx + ONE : r_idx;
   assign last_nxt = (r_nxt == cfg_r_q - ONE) && (m_nxt == cfg_m_q - ONE);

   // S0: sequencer. inc advances by step per new r; p advances by inc per m.
   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r   <= 1'b0;
         cfg_r_q  <= '0;
         cfg_m_q  <= '0;
         step_q   <= '0;
         r_idx    <= '0;
         m_idx    <= '0;
         inc      <= '0;
         s0_p     <= '0;
         s0_valid <= 1'b0;
         s0_last  <= 1'b0;
      end else if (start_ok) begin
         busy_r   <= 1'b1;
         cfg_r_q  <= bus.cfg_r;
         cfg_m_q  <= bus.cfg_m;
         step_q   <= bus.cfg_step;
         r_idx    <= '0;
         m_idx    <= '0;
         inc      <= '0;
         s0_p     <= '0;
         s0_valid <= 1'b1;
         s0_last  <= (bus.cfg_r == ONE) && (bus.cfg_m == ONE);
      end else begin
         if (en && s0_valid) begin
            if (s0_last) begin
               s0_valid <= 1'b0;
            end else begin
               m_idx   <= m_nxt;
               r_idx   <= r_nxt;
               inc     <= m_end ? wrap_add(inc, step_q) : inc;
               s0_p    <= m_end ? '0 : wrap_add(s0_p, inc);
               s0_last <= last_nxt;
            end
         end
         if (s2_valid && bus.out_ready && s2_last) busy_r <= 1'b0;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      q_c = 2'd0;
      o_c = AW'(s0_p);
      if (s0_p >= P_Q3) begin
         q_c = 2'd3;
         o_c = AW'(s0_p - P_Q3);
      end else if (s0_p >= P_Q2) begin
         q_c = 2'd2;
         o_c = AW'(s0_p - P_Q2);
      end else if (s0_p >= P_Q1) begin
         q_c = 2'd1;
         o_c = AW'(s0_p - P_Q1);
      end
   end

   // S1: fold into quadrant and offset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= '0;
         s1_o     <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
      end else if (en) begin
         s1_q     <= q_c;
         s1_o     <= o_c;
         s1_valid <= s0_valid;
         s1_last  <= s0_last;
      end
   end

   // S2: ROM read of C[o] and C[Q-o], with the quadrant carried alongside.
   twiddle_rom_q #(
      .MAX_N (MAX_N),
      .TW_W  (TW_W),
      .FRAC  (FRAC),
      .AW    (AW)
   ) u_rom (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .addr_a (s1_o),
      .addr_b (A_Q - s1_o),
      .data_a (rd_a),
      .data_b (rd_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_q     <= '0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
      end else if (en) begin
         s2_q     <= s1_q;
         s2_valid <= s1_valid;
         s2_last  <= s1_valid && s1_last;
      end
   end

   // Sign/swap depends only on registered values, so the word holds steady under stall
   // and reads as (0, 0) after reset (q = 0, both ROM registers cleared).
   always_comb begin
      re_c = rd_a;
      im_c = -rd_b;
      case (s2_q)
         2'd1: begin re_c = -rd_b; im_c = -rd_a; end
         2'd2: begin re_c = -rd_a; im_c = rd_b;  end
         2'd3: begin re_c = rd_b;  im_c = rd_a;  end
         default: ;
      endcase
   end

   assign bus.busy      = busy_r;
   assign bus.out_valid = s2_valid;
   assign bus.tw_last   = s2_last;
   assign bus.tw_re     = re_c;
   assign bus.tw_im     = im_c;

endmodule
